vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_refresh_timer.sv | 39 +++
 rtl/vram_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM definitions: SDRAM command opcodes and the default address width,
// common to the arbiter and the SDRAM engine.
package vram_pkg;

  localparam int VRAM_ADDR_W = 24;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_REFRESH = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

endpackage

// File: rtl/vram_refresh_timer.sv
// Auto-refresh interval timer: raises refresh_pending every REFRESH_CYCLES clocks
// and flags a sticky overrun if the previous request was never serviced.
module vram_refresh_timer #(
  parameter int REFRESH_CYCLES = 780
) (
  input  logic clk,
  input  logic reset,
  input  logic refresh_ack,
  output logic refresh_pending,
  output logic refresh_overrun
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             expire;

  assign expire = (count == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count           <= RELOAD;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      count <= expire ? RELOAD : count - CNT_W'(1);
      // A fresh expiry outranks the acknowledge of the request being retired.
      if (expire) begin
        refresh_pending <= 1'b1;
        if (refresh_pending && !refresh_ack) refresh_overrun <= 1'b1;
      end else if (refresh_ack) begin
        refresh_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one SDRAM command port between scanout reads, pixel writes
// and periodic auto-refresh, with write anti-starvation.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int REFRESH_CYCLES = 780,
  parameter int WR_STARVE      = 64,
  parameter int ADDR_W         = VRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [1:0]        mem_cmd_op,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_done,
  output logic              busy,
  output logic              refresh_overrun
);

  localparam int WAIT_W = $clog2(WR_STARVE + 1);

  arb_state_e        state;
  mem_op_e           op;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic [WAIT_W-1:0] wr_wait;
  logic              wr_starved;
  logic              refresh_pending;
  logic              refresh_ack;
  logic              handshake;
  logic              done_fire;
  mem_op_e           pick_op;
  logic [ADDR_W-1:0] pick_addr;

  vram_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk             (clk),
    .reset           (reset),
    .refresh_ack     (refresh_ack),
    .refresh_pending (refresh_pending),
    .refresh_overrun (refresh_overrun)
  );

  // Pulses are gated by reset so an abandoned transaction never reports a grant or completion.
  assign handshake   = !reset && valid && mem_cmd_ready;
  assign done_fire   = !reset && (state == WAIT) && mem_done;
  assign refresh_ack = handshake && (op == OP_REFRESH);
  assign rd_gnt      = handshake && (op == OP_READ);
  assign wr_gnt      = handshake && (op == OP_WRITE);
  assign rd_done     = done_fire && (op == OP_READ);
  assign wr_done     = done_fire && (op == OP_WRITE);
  assign wr_starved  = (wr_wait >= WAIT_W'(WR_STARVE));

  assign mem_cmd_valid = valid;
  assign mem_cmd_op    = op;
  assign mem_cmd_addr  = addr;
  assign busy          = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    pick_op   = OP_NONE;
    pick_addr = '0;
    if (refresh_pending) begin
      pick_op = OP_REFRESH;
    end else if (wr_req && wr_starved) begin
      pick_op   = OP_WRITE;
      pick_addr = wr_addr;
    end else if (rd_req) begin
      pick_op   = OP_READ;
      pick_addr = rd_addr;
    end else if (wr_req) begin
      pick_op   = OP_WRITE;
      pick_addr = wr_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= OP_NONE;
      addr  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_op != OP_NONE) begin
          state <= ISSUE;
          op    <= pick_op;
          addr  <= pick_addr;
          valid <= 1'b1;
        end
        ISSUE: if (mem_cmd_ready) begin
          state <= WAIT;
          valid <= 1'b0;
        end
        WAIT: if (mem_done) begin
          state <= IDLE;
          op    <= OP_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write age: counts while a write is refused, saturating at the starvation threshold.
  always_ff @(posedge clk) begin
    if (reset || wr_gnt)            wr_wait <= '0;
    else if (wr_req && !wr_starved) wr_wait <= wr_wait + WAIT_W'(1);
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed latency/priority/refresh/reset
// scenarios plus a randomized run against a cycle-level reference model.
module tb_vram_arbiter;

  localparam int RC = 16;
  localparam int WS = 64;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic          rd_gnt, rd_done, wr_gnt, wr_done;
  logic          mem_cmd_valid, busy, refresh_overrun;
  logic          mem_cmd_ready = 1'b0, mem_done = 1'b0;
  logic [1:0]    mem_cmd_op;
  logic [AW-1:0] mem_cmd_addr;

  always #5 clk = ~clk;

  vram_arbiter #(.REFRESH_CYCLES(RC), .WR_STARVE(WS), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_op(mem_cmd_op), .mem_cmd_addr(mem_cmd_addr), .mem_done(mem_done),
    .busy(busy), .refresh_overrun(refresh_overrun)
  );

  int checks = 0, failures = 0, cyc = 0;
  bit armed = 1'b0;

  // Reference model: phase 0 = no transaction, 1 = command offered, 2 = awaiting completion.
  int            m_phase, m_op, m_cnt, m_wait;
  bit            m_pend, m_ovr;
  logic [AW-1:0] m_addr;

  // Stimulus policy.
  int rd_pct = 0, wr_pct = 0, rdy_pct = 100, spur_pct = 0, dly_min = 1, dly_max = 1, done_at = -1;

  // Event recorders for directed scenarios.
  int first_valid, first_valid_op, first_rd_gnt, first_rd_done, first_wr_gnt, first_ovr, n_rd_done;
  int ref_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_records();
    first_valid = -1; first_valid_op = -1; first_rd_gnt = -1; first_rd_done = -1;
    first_wr_gnt = -1; first_ovr = -1; n_rd_done = 0;
    ref_q.delete();
  endtask

  task automatic compare();
    bit hs, dn;
    if (!armed) return;
    hs = !reset && m_phase == 1 && mem_cmd_ready;
    dn = !reset && m_phase == 2 && mem_done;
    check("valid", mem_cmd_valid, m_phase == 1);
    check("op", mem_cmd_op, (m_phase == 0) ? 0 : m_op);
    if (m_phase == 1 && m_op != 3) check("addr", mem_cmd_addr, m_addr);
    check("busy", busy, m_phase != 0);
    check("rd_gnt", rd_gnt, hs && m_op == 1);
    check("wr_gnt", wr_gnt, hs && m_op == 2);
    check("rd_done", rd_done, dn && m_op == 1);
    check("wr_done", wr_done, dn && m_op == 2);
    check("overrun", refresh_overrun, m_ovr);
    if (mem_cmd_valid && first_valid < 0) begin first_valid = cyc; first_valid_op = mem_cmd_op; end
    if (rd_gnt && first_rd_gnt < 0) first_rd_gnt = cyc;
    if (wr_gnt && first_wr_gnt < 0) first_wr_gnt = cyc;
    if (rd_done) begin n_rd_done++; if (first_rd_done < 0) first_rd_done = cyc; end
    if (mem_cmd_valid && mem_cmd_ready && mem_cmd_op == 2'b11) ref_q.push_back(cyc);
    if (refresh_overrun && first_ovr < 0) first_ovr = cyc;
  endtask

  task automatic model_advance();
    bit hs, ack, wgnt, expire;
    if (reset) begin
      m_phase = 0; m_op = 0; m_addr = '0; m_cnt = RC - 1; m_pend = 0; m_ovr = 0; m_wait = 0;
      armed = 1'b1;
      return;
    end
    hs     = m_phase == 1 && mem_cmd_ready;
    ack    = hs && m_op == 3;
    wgnt   = hs && m_op == 2;
    expire = m_cnt == 0;
    case (m_phase)
      0: begin
        if (m_pend)                      begin m_op = 3; m_addr = '0;      m_phase = 1; end
        else if (wr_req && m_wait >= WS) begin m_op = 2; m_addr = wr_addr; m_phase = 1; end
        else if (rd_req)                 begin m_op = 1; m_addr = rd_addr; m_phase = 1; end
        else if (wr_req)                 begin m_op = 2; m_addr = wr_addr; m_phase = 1; end
      end
      1: if (mem_cmd_ready) m_phase = 2;
      default: if (mem_done) begin m_phase = 0; m_op = 0; end
    endcase
    if (expire) begin
      if (m_pend && !ack) m_ovr = 1;
      m_pend = 1;
    end else if (ack) begin
      m_pend = 0;
    end
    m_cnt = expire ? RC - 1 : m_cnt - 1;
    if (wgnt) m_wait = 0;
    else if (wr_req && m_wait < WS) m_wait++;
  endtask

  task automatic tick();
    bit hs, g_rd, g_wr, was_reset;
    @(negedge clk);
    compare();
    @(posedge clk);
    was_reset = reset;
    hs   = armed && !reset && m_phase == 1 && mem_cmd_ready;
    g_rd = hs && m_op == 1;
    g_wr = hs && m_op == 2;
    model_advance();
    cyc++;
    #1;
    if (g_rd) rd_req = 1'b0;
    if (!rd_req && $urandom_range(99) < rd_pct) begin rd_req = 1'b1; rd_addr = AW'($urandom); end
    if (g_wr) wr_req = 1'b0;
    if (!wr_req && $urandom_range(99) < wr_pct) begin wr_req = 1'b1; wr_addr = AW'($urandom); end
    mem_cmd_ready = $urandom_range(99) < rdy_pct;
    if (was_reset) done_at = -1;
    if (hs) done_at = cyc - 1 + int'($urandom_range(dly_max, dly_min));
    mem_done = (cyc == done_at) || ($urandom_range(99) < spur_pct);
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_pct = 0; wr_pct = 0; spur_pct = 0;
    tick();
    tick();
    reset = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0; mem_done = 1'b0; done_at = -1;
    cyc = 0;
    clear_records();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int c0;
    clear_records();

    // Single read: latency from request to valid, grant and done.
    rdy_pct = 100; dly_min = 5; dly_max = 5;
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_valid", mem_cmd_valid, 0);
    check("reset_overrun", refresh_overrun, 0);
    run_to(10);
    rd_req = 1'b1; rd_addr = 24'h12_3456;
    run_to(20);
    check("lat_valid_cyc", first_valid, 11);
    check("lat_valid_op", first_valid_op, 1);
    check("lat_rd_gnt_cyc", first_rd_gnt, 11);
    check("lat_rd_done_cyc", first_rd_done, 16);

    // Simultaneous read and write: read first, write two cycles after rd_done.
    do_reset();
    run_to(2);
    rd_req = 1'b1; rd_addr = 24'h00_0100;
    wr_req = 1'b1; wr_addr = 24'h00_0200;
    run_to(20);
    check("both_rd_gnt_cyc", first_rd_gnt, 3);
    check("both_rd_done_cyc", first_rd_done, 8);
    check("both_wr_gnt_cyc", first_wr_gnt, 10);

    // Write starvation under a continuous read stream.
    dly_min = 1; dly_max = 1;
    do_reset();
    rd_pct = 100;
    rd_req = 1'b1; rd_addr = AW'($urandom);
    wr_req = 1'b1; wr_addr = 24'hAB_CDEF;
    while (first_wr_gnt < 0 && cyc < 400) tick();
    check("starve_wr_gnt_seen", first_wr_gnt >= 0, 1);
    check("starve_wr_gnt_late", first_wr_gnt >= WS + 1, 1);
    rd_pct = 0;
    run_to(cyc + 20);

    // Idle refresh cadence.
    dly_min = 2; dly_max = 2;
    do_reset();
    run_to(70);
    check("refresh_count", ref_q.size(), 4);
    foreach (ref_q[i]) check("refresh_cyc", ref_q[i], 17 + 16 * i);
    check("refresh_no_overrun", refresh_overrun, 0);

    // Stalled command port: overrun at second expiry, sticky afterwards.
    rdy_pct = 0;
    do_reset();
    run_to(40);
    check("overrun_first_cyc", first_ovr, 32);
    rdy_pct = 100;
    run_to(80);
    check("overrun_sticky", refresh_overrun, 1);

    // Reset while waiting for completion, then a late mem_done.
    dly_min = 100; dly_max = 100;
    do_reset();
    rd_req = 1'b1; rd_addr = 24'h55_0000;
    run_to(4);
    check("rst_in_wait_busy", busy, 1);
    reset = 1'b1; rd_req = 1'b0;
    tick();
    reset = 1'b0;
    mem_done = 1'b1;
    tick();
    check("rst_no_rd_done", n_rd_done, 0);
    first_valid = -1; first_rd_gnt = -1;
    c0 = cyc;
    rd_req = 1'b1; rd_addr = 24'h55_0040;
    run_to(c0 + 4);
    check("rst_reissue_valid", first_valid, c0 + 1);
    check("rst_reissue_gnt", first_rd_gnt, c0 + 1);

    // Randomized traffic with stalls, spurious completions and occasional resets.
    rdy_pct = 70; dly_min = 1; dly_max = 6;
    do_reset();
    rd_pct = 30; wr_pct = 25; spur_pct = 5;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
